// File: rtl/bht_predictor_if.sv
// Fetch/execute-facing bundle of the branch history table: lookup request,
// registered prediction, resolved-branch update and the ready flag.
interface bht_predictor_if;
  logic        ready;
  logic        lookup_en;
  logic [31:0] lookup_pc;
  logic        stall;
  logic        pred_valid;
  logic        pred_taken;
  logic [1:0]  pred_state;
  logic        update_en;
  logic [31:0] update_pc;
  logic        update_taken;

  // Pipeline side: issues lookups/updates, consumes predictions.
  modport master (
    input  ready,
    input  pred_valid,
    input  pred_taken,
    input  pred_state,
    output lookup_en,
    output lookup_pc,
    output stall,
    output update_en,
    output update_pc,
    output update_taken
  );

  // Predictor side.
  modport slave (
    output ready,
    output pred_valid,
    output pred_taken,
    output pred_state,
    input  lookup_en,
    input  lookup_pc,
    input  stall,
    input  update_en,
    input  update_pc,
    input  update_taken
  );
endinterface

// File: rtl/bht_predictor.sv
// Branch history table: 2^INDEX_W two-bit saturating counters indexed by
// PC[INDEX_W+1:2]. Lookups return a registered prediction one cycle later;
// updates read-modify-write the indexed counter. After reset an init
// sequencer sweeps every entry to INIT_STATE before traffic is accepted.
module bht_predictor #(
  parameter int         INDEX_W    = 10,
  parameter logic [1:0] INIT_STATE = 2'b01
) (
  input  logic           clk,
  input  logic           resetn,
  bht_predictor_if.slave bus
);

  localparam int DEPTH = 1 << INDEX_W;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [INDEX_W-1:0] init_ptr_q;
  logic               run;
  logic               init_last;

  logic [1:0]         bht_q [DEPTH];

  logic [INDEX_W-1:0] lk_idx_p0;
  logic [INDEX_W-1:0] up_idx_p0;
  logic [1:0]         up_cur_p0;
  logic [1:0]         up_next_p0;
  logic [1:0]         lk_raw_p0;
  logic [1:0]         lk_val_p0;
  logic               bypass_p0;

  logic               wr_en_p0;
  logic [INDEX_W-1:0] wr_idx_p0;
  logic [1:0]         wr_data_p0;

  logic               vld_p1;
  logic               pred_taken_p1;
  logic [1:0]         pred_state_p1;

  // Standard two-bit saturating counter step.
  function automatic logic [1:0] sat_next(input logic [1:0] cur, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      nxt = (cur == 2'b11) ? 2'b11 : cur + 2'd1;
    end else begin
      nxt = (cur == 2'b00) ? 2'b00 : cur - 2'd1;
    end
    return nxt;
  endfunction

  assign run       = (state_q == S_RUN);
  assign init_last = &init_ptr_q;

  // ---- stage p0: index decode, combinational table read, update and bypass
  assign lk_idx_p0  = bus.lookup_pc[INDEX_W+1:2];
  assign up_idx_p0  = bus.update_pc[INDEX_W+1:2];
  assign up_cur_p0  = bht_q[up_idx_p0];
  assign up_next_p0 = sat_next(up_cur_p0, bus.update_taken);
  assign lk_raw_p0  = bht_q[lk_idx_p0];

  // A same-cycle update to the looked-up entry forwards its new value so the
  // prediction never reflects a counter that is being overwritten.
  assign bypass_p0  = bus.update_en && (up_idx_p0 == lk_idx_p0);
  assign lk_val_p0  = bypass_p0 ? up_next_p0 : lk_raw_p0;

  // Single write port shared by the init sweep and the update path.
  assign wr_en_p0   = !run || bus.update_en;
  assign wr_idx_p0  = run ? up_idx_p0  : init_ptr_q;
  assign wr_data_p0 = run ? up_next_p0 : INIT_STATE;

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: leave INIT once the last entry has been written.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  if (init_last) state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      default: state_d = S_INIT;
    endcase
  end

  // Init sweep pointer, advances one entry per cycle while in INIT.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      init_ptr_q <= '0;
    end else if (!run) begin
      init_ptr_q <= init_ptr_q + 1'b1;
    end
  end

  // Counter storage; contents are established by the init sweep, not reset.
  always_ff @(posedge clk) begin
    if (wr_en_p0) begin
      bht_q[wr_idx_p0] <= wr_data_p0;
    end
  end

  // ---- stage p1: registered prediction, frozen while stalled
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_p1        <= 1'b0;
      pred_taken_p1 <= 1'b0;
      pred_state_p1 <= 2'b01;
    end else if (run && !bus.stall) begin
      vld_p1 <= bus.lookup_en;
      if (bus.lookup_en) begin
        pred_state_p1 <= lk_val_p0;
        pred_taken_p1 <= lk_val_p0[1];
      end
    end
  end

  assign bus.ready      = run;
  assign bus.pred_valid = vld_p1;
  assign bus.pred_taken = pred_taken_p1;
  assign bus.pred_state = pred_state_p1;

  // PC bits outside the index field do not participate in prediction.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.lookup_pc[31:INDEX_W+2], bus.lookup_pc[1:0],
                            bus.update_pc[31:INDEX_W+2], bus.update_pc[1:0]};

endmodule
